// File: rtl/scene_pkg.sv
// scene_pkg: shared phase encoding, widths and per-scene hold lengths for the scene sequencer.
package scene_pkg;
  localparam int SCENE_W = 3;
  localparam int FADE_W  = 2;
  typedef enum logic [1:0] {
    PH_FADE_IN  = 2'd0,
    PH_HOLD     = 2'd1,
    PH_FADE_OUT = 2'd2
  } phase_e;
  // Frames each scene holds at full brightness; index 0 is the rightmost entry.
  localparam logic [7:0][7:0] HOLD_LEN = {8'd200, 8'd90, 8'd30, 8'd120, 8'd60, 8'd0, 8'd1, 8'd4};
  function automatic logic [7:0] hold_last(input logic [SCENE_W-1:0] id);
    return (HOLD_LEN[id] == 8'd0) ? 8'd0 : HOLD_LEN[id] - 8'd1;
  endfunction
endpackage

// File: rtl/fade_step_counter.sv
// fade_step_counter: prescaler counting enabled ticks modulo STEPS, flagging the wrapping tick.
module fade_step_counter #(
  parameter int STEPS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);
  localparam int W = (STEPS > 1) ? $clog2(STEPS) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_o = en_i && (cnt_q == W'(STEPS - 1));
  always_comb cnt_d = clr_i ? '0 : en_i ? (wrap_o ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: rotates demo scenes through fade-in, hold and fade-out phases on frame ticks.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int NUM_SCENES       = 8,
  parameter int FADE_STEP_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic               skip,
  output logic [SCENE_W-1:0] scene_id,
  output logic [1:0]         phase,
  output logic [FADE_W-1:0]  fade,
  output logic [7:0]         scene_frame,
  output logic               scene_start,
  output logic               loop_done
);
  logic [SCENE_W-1:0] scene_q, scene_d;
  phase_e             phase_q, phase_d;
  logic [FADE_W-1:0]  fade_q, fade_d;
  logic [7:0]         frame_q, frame_d, hold_q, hold_d;
  logic               start_q, start_d, loop_q, loop_d, pend_q, pend_d;
  logic               act, skip_now, wrap, step_en, step_clr, adv;

  assign act      = frame_tick && !pause;
  assign skip_now = skip || pend_q;
  assign step_en  = act && (phase_q != PH_HOLD);

  fade_step_counter #(.STEPS(FADE_STEP_FRAMES)) u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (step_en),
    .clr_i (step_clr),
    .wrap_o(wrap)
  );

  always_comb begin
    scene_d  = scene_q;
    phase_d  = phase_q;
    fade_d   = fade_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    start_d  = 1'b0;
    loop_d   = 1'b0;
    step_clr = 1'b0;
    adv      = 1'b0;
    pend_d   = act ? 1'b0 : (pend_q || skip);
    if (act) begin
      frame_d = (frame_q == 8'hFF) ? frame_q : frame_q + 8'd1;
      if (phase_q == PH_FADE_IN && skip_now && fade_q == '0) begin
        adv = 1'b1;
      end else if (phase_q != PH_FADE_OUT && skip_now) begin
        phase_d  = PH_FADE_OUT;
        step_clr = 1'b1;
      end else if (phase_q == PH_FADE_IN && wrap) begin
        fade_d = fade_q + 1'b1;
        if (fade_q == 2'd2) begin
          phase_d = PH_HOLD;
          hold_d  = 8'd0;
        end
      end else if (phase_q == PH_HOLD) begin
        if (hold_q == hold_last(scene_q)) begin
          phase_d  = PH_FADE_OUT;
          step_clr = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end else if (phase_q == PH_FADE_OUT && wrap) begin
        fade_d = fade_q - 1'b1;
        adv    = (fade_q == 2'd1);
      end
    end
    // Scene advance overrides whatever the phase logic chose above.
    if (adv) begin
      loop_d   = (scene_q == SCENE_W'(NUM_SCENES - 1));
      scene_d  = loop_d ? '0 : scene_q + 1'b1;
      phase_d  = PH_FADE_IN;
      fade_d   = '0;
      frame_d  = 8'd0;
      hold_d   = 8'd0;
      start_d  = 1'b1;
      step_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scene_q <= '0;
      phase_q <= PH_FADE_IN;
      fade_q  <= '0;
      frame_q <= 8'd0;
      hold_q  <= 8'd0;
      start_q <= 1'b0;
      loop_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      scene_q <= scene_d;
      phase_q <= phase_d;
      fade_q  <= fade_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      loop_q  <= loop_d;
      pend_q  <= pend_d;
    end
  end

  assign scene_id    = scene_q;
  assign phase       = phase_q;
  assign fade        = fade_q;
  assign scene_frame = frame_q;
  assign scene_start = start_q;
  assign loop_done   = loop_q;
endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed scoreboard bench for scene_sequencer with three short scenes.
module tb_scene_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, pause = 1'b0, skip = 1'b0;
  logic [2:0] scene_id;
  logic [1:0] phase, fade;
  logic [7:0] scene_frame;
  logic       scene_start, loop_done;
  int         checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  string       nm_q[$];

  scene_sequencer #(.NUM_SCENES(3), .FADE_STEP_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause), .skip(skip),
    .scene_id(scene_id), .phase(phase), .fade(fade), .scene_frame(scene_frame),
    .scene_start(scene_start), .loop_done(loop_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pack(input int s, p, f, fr, st, lp);
    return {3'(s), 2'(p), 2'(f), 8'(fr), 1'(st), 1'(lp)};
  endfunction

  function automatic string show(input logic [15:0] v);
    return $sformatf("s=%0d p=%0d f=%0d fr=%0d st=%0b lp=%0b", v[15:13], v[12:11], v[10:9], v[8:1], v[1'b0 ? 0 : 1], v[0]);
  endfunction

  // Monitor: each pushed expectation describes the outputs after the following clock edge.
  always @(posedge clk) begin
    logic [15:0] e, a;
    string n;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = {scene_id, phase, fade, scene_frame, scene_start, loop_done};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %s want %s", n, show(a), show(e));
      end
    end
  end

  task automatic t(input string nm, input bit r, ft, pa, sk, input int s, p, f, fr, st, lp);
    @(negedge clk);
    rst_n = r; frame_tick = ft; pause = pa; skip = sk;
    exp_q.push_back(pack(s, p, f, fr, st, lp));
    nm_q.push_back(nm);
  endtask

  task automatic tk(input string nm, input int s, p, f, fr, st, lp);
    t(nm, 1, 1, 0, 0, s, p, f, fr, st, lp);
  endtask

  task automatic fade_in6(input string nm, input int s);
    for (int i = 1; i <= 6; i++) tk(nm, s, (i == 6) ? 1 : 0, i / 2, i, 0, 0);
  endtask

  // Scenes whose hold is a single frame: fade-in, one hold frame, fade-out minus the advancing tick.
  task automatic short_scene(input string nm, input int s);
    fade_in6(nm, s);
    tk({nm, "_hold1"}, s, 2, 3, 7, 0, 0);
    for (int k = 1; k <= 5; k++) tk({nm, "_fo"}, s, 2, 3 - k / 2, 7 + k, 0, 0);
  endtask

  task automatic check_now(input string nm);
    logic [15:0] a;
    a = {scene_id, phase, fade, scene_frame, scene_start, loop_done};
    checks++;
    if (a !== 16'd0) begin
      failures++;
      $display("FAIL %s: got %s want all zero", nm, show(a));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 100; i++) t("idle_after_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fade_in6("s0_fadein", 0);
    for (int k = 7; k <= 9; k++) tk("s0_hold", 0, 1, 3, k, 0, 0);
    tk("s0_enter_fo", 0, 2, 3, 10, 0, 0);
    for (int k = 1; k <= 5; k++) tk("s0_fo", 0, 2, 3 - k / 2, 10 + k, 0, 0);
    tk("s0_advance", 1, 0, 0, 0, 1, 0);
    t("s1_start_low", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    short_scene("s1", 1);
    tk("s1_advance", 2, 0, 0, 0, 1, 0);
    short_scene("s2", 2);
    tk("wrap_loop", 0, 0, 0, 0, 1, 1);
    t("loop_low", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fade_in6("s0b_fadein", 0);
    for (int i = 0; i < 5; i++) t("paused", 1, 1, 1, i == 2, 0, 1, 3, 6, 0, 0);
    tk("skip_after_pause", 0, 2, 3, 7, 0, 0);
    tk("fo_a", 0, 2, 3, 8, 0, 0);
    tk("fo_b", 0, 2, 2, 9, 0, 0);
    t("skip_in_fo", 1, 1, 0, 1, 0, 2, 2, 10, 0, 0);
    tk("fo_c", 0, 2, 1, 11, 0, 0);
    tk("fo_d", 0, 2, 1, 12, 0, 0);
    tk("fo_advance", 1, 0, 0, 0, 1, 0);
    t("skip_fade0", 1, 1, 0, 1, 2, 0, 0, 0, 1, 0);
    t("skip_fade0_wrap", 1, 1, 0, 1, 0, 0, 0, 0, 1, 1);
    t("skip_fade0_s1", 1, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    tk("s1c_t1", 1, 0, 0, 1, 0, 0);
    tk("s1c_t2", 1, 0, 1, 2, 0, 0);
    t("skip_fadein", 1, 1, 0, 1, 1, 2, 1, 3, 0, 0);
    tk("s1c_fo", 1, 2, 1, 4, 0, 0);
    @(negedge clk);
    frame_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_now("async_reset");
    for (int i = 0; i < 3; i++) t("in_reset", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    t("release", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fade_in6("post_reset_fadein", 0);
    t("post_reset_idle", 1, 0, 0, 0, 0, 1, 3, 6, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scene_sequencer.md
SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 SHALL have parameter NUM_SCENES, default 8, meaning the number of demo scenes in the rotation (2..8).
REQ-002 SHALL have parameter FADE_STEP_FRAMES, default 8, meaning frames per fade-level step (1..16).
REQ-003 SHALL have port clk  input  1  the single system clock (VGA pixel clock domain).
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse, once per frame, from the timing generator.
REQ-006 SHALL have port pause  input  1  level; while high, all sequencing is frozen.
REQ-007 SHALL have port skip  input  1  one-cycle request to end the current scene early.
REQ-008 SHALL have port scene_id  output  3  index of the active scene.
REQ-009 SHALL have port phase  output  2  0=FADE_IN, 1=HOLD, 2=FADE_OUT.
REQ-010 SHALL have port fade  output  2  brightness level 0..3 applied to the 2-bit colour channels.
REQ-011 SHALL have port scene_frame  output  8  frames elapsed since scene start, saturating at 255.
REQ-012 SHALL have port scene_start  output  1  one-cycle pulse on every scene change.
REQ-013 SHALL have port loop_done  output  1  one-cycle pulse when scene_id wraps to 0.

Function
REQ-014 All outputs SHALL be registered; state SHALL advance only on a clk edge where frame_tick=1 and pause=0 (an "active tick").
REQ-015 On each active tick, scene_frame SHALL increment, saturating at 255.
REQ-016 FADE_IN: internal step counter SHALL count active ticks; at count FADE_STEP_FRAMES-1 it SHALL clear and fade SHALL increment; the edge where fade becomes 3 SHALL also enter HOLD with the hold counter at 0.
REQ-017 HOLD: the hold counter SHALL count active ticks; on the tick where it equals HOLD_LEN[scene_id]-1 (HOLD_LEN of 0 treated as 1), phase SHALL become FADE_OUT with the step counter cleared.
REQ-018 FADE_OUT: fade SHALL decrement per FADE_STEP_FRAMES active ticks; the edge where fade becomes 0 SHALL also set scene_id to scene_id+1 (NUM_SCENES-1 wraps to 0), clear scene_frame, enter FADE_IN, and pulse scene_start.
REQ-019 loop_done SHALL pulse on the same edge as scene_start when scene_id wraps to 0.
REQ-020 A skip pulse SHALL set a pending flag, held through pause, consumed on the next active tick, including one coincident with the skip pulse.
REQ-021 A consumed skip in FADE_IN or HOLD SHALL enter FADE_OUT with the step counter cleared and fade unchanged; in FADE_OUT it SHALL be discarded.
REQ-022 A skip consumed in FADE_IN at fade=0 SHALL advance the scene on that same edge, as in REQ-018.
REQ-023 scene_start and loop_done SHALL be low on every cycle other than the advancing edge.

Reset
REQ-024 rst_n low SHALL immediately force: scene_id=0, phase=FADE_IN, fade=0, scene_frame=0, scene_start=0, loop_done=0, step/hold counters=0, skip pending=0.
REQ-025 Reset asserted mid-operation SHALL abandon the scene with no pulse; sequencing resumes from scene 0 at the first active tick after release.

Structure
REQ-026 A shared package scene_pkg SHALL hold the phase encoding constants, the HOLD_LEN table (8 x 8-bit frame counts), and the scene_id/fade widths.
REQ-027 One sub-module, fade_step_counter (prescaler counting active ticks modulo FADE_STEP_FRAMES, with clear), SHALL be instantiated; all else stays in scene_sequencer.

Verification (NUM_SCENES=3, FADE_STEP_FRAMES=2, HOLD_LEN={4,1,0})
REQ-028 Reset released, no ticks -> all outputs 0, phase=0 for 100 cycles.
REQ-029 6 active ticks -> fade steps 1,2,3 at ticks 2,4,6; phase=HOLD, scene_frame=6.
REQ-030 10 more ticks (16 total) -> FADE_OUT after tick 10, fade 0 at tick 16 with scene_id=1, phase=FADE_IN, scene_frame=0, scene_start pulsed exactly one cycle.
REQ-031 Run through scene 2 (HOLD_LEN 0 -> 1 frame) -> scene_id wraps to 0 with scene_start and loop_done on the same cycle.
REQ-032 pause high across 5 frame_ticks in HOLD -> no output changes; skip pulsed while paused -> FADE_OUT entered on first unpaused tick, fade still 3.
REQ-033 rst_n dropped mid-FADE_OUT of scene 1 -> outputs zero asynchronously, no scene_start pulse; after release, 6 ticks reproduce REQ-029.
